// File: rtl/div_pkg.sv
// Shared types for the sequential divider: FSM state encoding and the result flag bundle.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
    } flags_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] pr,
    input  logic [N-1:0] dvs,
    input  logic         bit_in,
    output logic [N-1:0] pr_next,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // pr < dvs always holds, so a non-negative difference fits back into N bits.
    assign shifted = {pr, bit_in};
    assign diff    = shifted - {1'b0, dvs};
    assign q_bit   = ~diff[N];
    assign pr_next = q_bit ? diff[N-1:0] : shifted[N-1:0];

endmodule

// File: rtl/division_seq.sv
// Sequential restoring divider, one quotient bit per cycle, results registered on done.
// Two's-complement operation is built only when DIV_SIGNED_EN is defined.
module division_seq
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         signed_mode,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         flagC,
    output logic         flagV,
    output logic         flagZ
);

    localparam int CW = $clog2(N);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  pr;
    logic [N-1:0]  dvd;
    logic [N-1:0]  dvs;
    logic          div0;
    flags_t        flg;

    logic [N-1:0]  pr_nx;
    logic          q_bit;
    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [N-1:0]  res_q;
    logic [N-1:0]  res_r;
    flags_t        res_f;

    div_step #(.N(N)) u_step (
        .pr      (pr),
        .dvs     (dvs),
        .bit_in  (dvd[N-1]),
        .pr_next (pr_nx),
        .q_bit   (q_bit)
    );

`ifdef DIV_SIGNED_EN
    function automatic logic [N-1:0] neg(input logic [N-1:0] x);
        return -x;
    endfunction

    logic signed [N-1:0] a_s;
    logic signed [N-1:0] b_s;
    logic                a_neg;
    logic                b_neg;
    logic                ovf_in;
    logic                neg_q;
    logic                neg_r;
    logic                ovf;

    assign a_s    = a;
    assign b_s    = b;
    assign a_neg  = signed_mode && (a_s < 0);
    assign b_neg  = signed_mode && (b_s < 0);
    assign ovf_in = signed_mode && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
    assign a_mag  = a_neg ? neg(a) : a;
    assign b_mag  = b_neg ? neg(b) : b;
`else
    logic unused_sm;
    assign unused_sm = signed_mode;
    assign a_mag     = a;
    assign b_mag     = b;
`endif

    // Final result: sign fixup of the magnitudes, or the fixed divide-by-zero pattern.
    always_comb begin
        res_q   = dvd;
        res_r   = pr;
        res_f   = '0;
`ifdef DIV_SIGNED_EN
        if (neg_q) res_q = neg(dvd);
        if (neg_r) res_r = neg(pr);
        res_f.v = ovf;
`endif
        if (div0) begin
            res_q   = '1;
            res_r   = dvd;
            res_f.v = 1'b1;
        end
        res_f.c = !div0 && (res_r != '0);
        res_f.z = !div0 && (res_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pr        <= '0;
            dvd       <= '0;
            dvs       <= '0;
            div0      <= 1'b0;
            flg       <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        div0  <= (b == '0);
                        dvd   <= (b == '0) ? a : a_mag;
                        dvs   <= b_mag;
                        pr    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= (b == '0) ? DONE : BUSY;
`ifdef DIV_SIGNED_EN
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        ovf   <= ovf_in;
`endif
                    end
                end
                BUSY: begin
                    // dvd shifts dividend bits out the top and quotient bits in the bottom.
                    pr  <= pr_nx;
                    dvd <= {dvd[N-2:0], q_bit};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N-1)) state <= DONE;
                end
                DONE: begin
                    quotient  <= res_q;
                    remainder <= res_r;
                    flg       <= res_f;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign flagC = flg.c;
    assign flagV = flg.v;
    assign flagZ = flg.z;

endmodule

// File: doc/division_seq.md
DIVISION_SEQ -- requirements
Module: division_seq

Interface
REQ-001 Parameter N, default 8: operand/result width, N >= 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  N  dividend; captured when start is accepted.
REQ-006 b  input  N  divisor; captured when start is accepted.
REQ-007 signed_mode  input  1  1 = two's-complement operands; captured with a/b.
REQ-008 quotient  output  N  registered quotient.
REQ-009 remainder  output  N  registered remainder.
REQ-010 busy  output  1  high while an operation is in flight.
REQ-011 done  output  1  one-cycle pulse marking valid results.
REQ-012 flagC / flagV / flagZ  output  1 each  remainder-nonzero / overflow-or-div0 / quotient-zero.

Function
REQ-013 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 IDLE->BUSY when start=1 and b!=0; IDLE->DONE when start=1 and b==0; DONE->IDLE unconditionally.
REQ-015 BUSY performs exactly N restoring shift-subtract iterations (one per cycle) on magnitudes; BUSY->DONE after the Nth.
REQ-016 Latency: done high exactly N+1 rising edges after the accepting edge (b!=0); 1 edge after it for b==0.
REQ-017 quotient, remainder and flags update on the edge done rises and hold until the next done; no intermediate values appear on outputs.
REQ-018 busy = 1 in BUSY and DONE, 0 in IDLE; start while busy is ignored, with no queueing.
REQ-019 Divide-by-zero: quotient = all ones, remainder = a, flagV = 1, flagC = 0, flagZ = 0.
REQ-020 Unsigned: quotient = floor(a/b), remainder = a mod b, flagV = 0 unless b==0.
REQ-021 Signed: quotient truncates toward zero, remainder takes the sign of a, and a = q*b + r holds.
REQ-022 Signed overflow (a = -2^(N-1), b = -1): quotient = -2^(N-1), remainder = 0, flagV = 1.
REQ-023 flagZ = (quotient == 0); flagC = (remainder != 0).

Reset
REQ-024 rst_n low forces IDLE immediately, independent of clk.
REQ-025 On reset: quotient = 0, remainder = 0, busy = 0, done = 0, flags = 0, internal registers = 0.
REQ-026 Reset mid-operation abandons the operation; no done is produced for it.

Configuration
REQ-027 Macro DIV_SIGNED_EN defined: signed_mode is honoured per REQ-021/022.
REQ-028 Macro DIV_SIGNED_EN undefined: signed_mode is ignored, all operations are unsigned, and sign-fixup logic is not built; the port remains present.

Structure
REQ-029 Package div_pkg holds the FSM state enum (IDLE, BUSY, DONE) and a packed flag struct {C, V, Z}.
REQ-030 Sub-module div_step: combinational single restoring iteration (partial remainder, divisor, next dividend bit -> new partial remainder, quotient bit), instantiated once and reused each cycle.

Verification (N=8)
REQ-031 a=13, b=4, unsigned -> q=3, r=1, C=1, V=0, Z=0; done 9 edges after start.
REQ-032 a=3, b=7 -> q=0, r=3, Z=1, C=1; then a=200, b=0 -> q=0xFF, r=200, V=1, done 1 edge after start.
REQ-033 DIV_SIGNED_EN: a=0xF9 (-7), b=2 signed -> q=0xFD (-3), r=0xFF (-1), C=1; a=0x80, b=0xFF signed -> q=0x80, r=0, V=1.
REQ-034 Without DIV_SIGNED_EN: a=0xF9, b=2, signed_mode=1 -> q=124, r=1.
REQ-035 start pulsed 3 cycles into BUSY with new operands -> ignored; original result delivered, exactly one done.
REQ-036 rst_n low for one cycle at iteration 4 -> outputs zero immediately, no done; next start completes normally.
